// File: rtl/aes_arb_pkg.sv
// ============================================================================
// Module  : aes_arb_pkg
// Brief   : Shared types and defaults for the AES engine job arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package aes_arb_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int DEF_TIMEOUT_CYC = 64;
   localparam int DEF_GAP_CYC     = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// ============================================================================
// Module  : rr_select
// Brief   : Combinational round-robin picker starting the scan at ptr.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_select
   import aes_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   localparam int C_SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [C_SEL_W-1:0] w_pos;

   // First valid request found at offset 0, 1, ... from ptr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      w_pos = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = C_SEL_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[w_pos]) begin
            grant[w_pos] = 1'b1;
            idx          = ID_W'(w_pos);
            any          = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes_job_arbiter.sv
// ============================================================================
// Module  : aes_job_arbiter
// Brief   : Shares one AES-128 engine between requesters, one job in flight.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module aes_job_arbiter
   import aes_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = AES_BLOCK_W,
   parameter int ID_W        = 3,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic                        clk,
   input  logic                        g_rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [DATA_W-1:0]           resp_data,
   output logic [ID_W-1:0]             resp_id,
   output logic                        resp_err,
   output logic                        busy,
   output logic                        aes_enable,
   output logic [DATA_W-1:0]           aes_datain,
   input  logic [DATA_W-1:0]           aes_dataout,
   input  logic                        aes_done
);

   localparam int C_TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int C_GAP_W = $clog2(GAP_CYC + 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [C_TMR_W-1:0]  r_timer;
   logic [C_GAP_W-1:0]  r_gap_cnt;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic                w_any;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_take;
   logic                w_fin_ok;
   logic                w_fin_to;
   logic                w_resp_fire;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_select (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .grant (w_grant),
      .idx   (w_idx),
      .any   (w_any)
   );

   // Gated by reset so the ready lines are quiet while reset is held.
   assign req_ready = (g_rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
   assign busy      = (r_state != ST_IDLE);
   assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_grant[k]) begin
            w_sel_data = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge g_rst_n) begin
      if (!g_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_fin_ok    = 1'b0;
      w_fin_to    = 1'b0;
      w_resp_fire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_take      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // A done arriving on the timeout cycle still delivers the result.
            if (aes_done) begin
               w_fin_ok    = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (r_timer == C_TMR_W'(TIMEOUT_CYC - 1)) begin
               w_fin_to    = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               w_resp_fire = 1'b1;
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == C_GAP_W'(GAP_CYC - 1)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge g_rst_n) begin
      if (!g_rst_n) begin
         r_rr_ptr   <= '0;
         r_timer    <= '0;
         r_gap_cnt  <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         resp_err   <= 1'b0;
         aes_enable <= 1'b0;
         aes_datain <= '0;
      end else begin
         if (w_take) begin
            aes_datain <= w_sel_data;
            resp_id    <= w_idx;
            r_rr_ptr   <= w_ptr_nxt;
            r_timer    <= '0;
            aes_enable <= 1'b1;
         end
         if (r_state == ST_RUN) begin
            r_timer <= r_timer + C_TMR_W'(1);
         end
         if (w_fin_ok) begin
            resp_data  <= aes_dataout;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            aes_enable <= 1'b0;
         end
         if (w_fin_to) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            aes_enable <= 1'b0;
         end
         if (w_resp_fire) begin
            resp_valid <= 1'b0;
            r_gap_cnt  <= '0;
         end
         if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + C_GAP_W'(1);
         end
      end
   end

endmodule

`default_nettype wire
